// File: rtl/alu_exec_stage_if.sv
// Bundle of the request, ALU-drive, result and flag signals of the execute stage.
// The stage itself connects through the slave modport; its environment uses master.
interface alu_exec_stage_if #(
  parameter int N  = 4,
  parameter int TW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic [3:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          in_setf;

  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [2:0]    alu_ctrl;
  logic          alu_cin;
  logic [N-1:0]  alu_f;
  logic          alu_cout;
  logic          alu_v;
  logic          alu_z;

  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_f;
  logic [TW-1:0] out_tag;

  logic [3:0]    flags;
  logic          flags_clr;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, in_setf,
    output in_ready,
    output alu_a, alu_b, alu_ctrl, alu_cin,
    input  alu_f, alu_cout, alu_v, alu_z,
    output out_valid, out_f, out_tag,
    input  out_ready,
    output flags,
    input  flags_clr
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, in_setf,
    input  in_ready,
    input  alu_a, alu_b, alu_ctrl, alu_cin,
    output alu_f, alu_cout, alu_v, alu_z,
    input  out_valid, out_f, out_tag,
    output out_ready,
    input  flags,
    output flags_clr
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered execute stage around an external combinational ALU: latches a request,
// lets the ALU settle for one cycle, then offers the result and updates {N,Z,C,V}.
module alu_exec_stage #(
  parameter int N  = 4,
  parameter int TW = 3
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_stage_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [2:0]    r_ctrl;
  logic          r_cin;
  logic [TW-1:0] r_tag;
  logic          r_setf;
  logic [N-1:0]  r_f;
  logic [TW-1:0] r_out_tag;
  logic          r_out_valid;
  logic [3:0]    r_flags;

  logic          w_in_ready;
  logic          w_accept;

  // DONE passes writeback's ready straight through so a new op can enter on the
  // same edge the current result leaves.
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_ctrl      <= '0;
      r_cin       <= 1'b0;
      r_tag       <= '0;
      r_setf      <= 1'b0;
      r_f         <= '0;
      r_out_tag   <= '0;
      r_out_valid <= 1'b0;
      r_flags     <= 4'b0000;
    end else begin
      if (w_accept) begin
        r_a    <= bus.in_a;
        r_b    <= bus.in_b;
        r_ctrl <= bus.in_op[3:1];
        r_cin  <= bus.in_op[0];
        r_tag  <= bus.in_tag;
        r_setf <= bus.in_setf;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_f         <= bus.alu_f;
          r_out_tag   <= r_tag;
          r_out_valid <= 1'b1;
          if (r_setf) begin
            r_flags <= {bus.alu_f[N-1], bus.alu_z, bus.alu_cout, bus.alu_v};
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= bus.in_valid ? S_EXEC : S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase

      // Placed last so a clear overrides a simultaneous flag capture.
      if (bus.flags_clr) begin
        r_flags <= 4'b0000;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.alu_ctrl  = r_ctrl;
  assign bus.alu_cin   = r_cin;
  assign bus.out_valid = r_out_valid;
  assign bus.out_f     = r_f;
  assign bus.out_tag   = r_out_tag;
  assign bus.flags     = r_flags;
endmodule
